// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 16-channel mux scan controller.
// Optional feature macro used by mux_scan_ctrl: MUX_SCAN_CHANGE_DETECT_EN.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The SAMPLE cycle is the last of each channel's SETTLE+1 cycles, so the
  // counter only has to cover SETTLE-1 further cycles after its load.
  function automatic logic [CNT_W-1:0] settle_load(input int unsigned settle);
    return (settle == 0) ? '0 : CNT_W'(settle - 1);
  endfunction

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter with a zero flag; paces the per-channel settle time.
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an external 16:1 mux channel by channel and captures a 16-bit frame.
// Define MUX_SCAN_CHANGE_DETECT_EN to add the chg/chg_any frame-change outputs.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mux_y,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] frame
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  ,
  output logic [NUM_CH-1:0] chg,
  output logic              chg_any
`endif
);

  // With SETTLE==0 the sample cycle alone makes up the one-cycle channel slot.
  localparam state_t           ENTRY    = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [CNT_W-1:0] LOAD_VAL = settle_load(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [NUM_CH-1:0] frame_nxt;
  logic [NUM_CH-1:0] shadow, shadow_nxt;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero_c;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic [NUM_CH-1:0] chg_nxt;
  logic              chg_any_nxt;
`endif

  mux_scan_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .zero_c   (cnt_zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sel    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      frame  <= '0;
      shadow <= '0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      chg     <= '0;
      chg_any <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      frame  <= frame_nxt;
      shadow <= shadow_nxt;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
      chg     <= chg_nxt;
      chg_any <= chg_any_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    frame_nxt  = frame;
    shadow_nxt = shadow;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    chg_nxt     = chg;
    chg_any_nxt = chg_any;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          sel_nxt   = '0;
          busy_nxt  = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ENTRY;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_c) begin
          state_nxt = ST_SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        shadow_nxt[sel] = mux_y;
        if (sel == LAST_SEL) begin
          // Publish on entry to DONE so frame is new while done is high.
          frame_nxt = shadow_nxt;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
          chg_nxt     = frame ^ shadow_nxt;
          chg_any_nxt = |(frame ^ shadow_nxt);
`endif
        end else begin
          sel_nxt   = sel + SEL_W'(1);
          cnt_load  = 1'b1;
          state_nxt = ENTRY;
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: one instance with SETTLE=2, one with SETTLE=0.
// Build with MUX_SCAN_CHANGE_DETECT_EN defined to also cover chg/chg_any.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst2, start2, y2, busy2, done2;
  logic [3:0]  sel2;
  logic [15:0] frame2, a2;
  logic        rst0, start0, y0, busy0, done0;
  logic [3:0]  sel0;
  logic [15:0] frame0, a0;
`ifdef MUX_SCAN_CHANGE_DETECT_EN
  logic [15:0] chg2, chg0;
  logic        chg_any2, chg_any0;
`endif

  assign y2 = a2[sel2];
  assign y0 = a0[sel0];

  mux_scan_ctrl #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .mux_y(y2),
    .sel(sel2), .busy(busy2), .done(done2), .frame(frame2)
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    , .chg(chg2), .chg_any(chg_any2)
`endif
  );

  mux_scan_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .mux_y(y0),
    .sel(sel0), .busy(busy0), .done(done0), .frame(frame0)
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    , .chg(chg0), .chg_any(chg_any0)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_frame(input string tag, input logic [15:0] obs);
    int sz;
    sz = exp_q.size();
    if (sz == 0) check({tag, " scoreboard empty"}, 32'(sz), 32'd1);
    else         check(tag, 32'(obs), 32'(exp_q.pop_front()));
  endtask

  // One full scan on the SETTLE=2 instance; done must come 48 edges after acceptance.
  task automatic scan2(input logic [15:0] a);
    int seen;
    a2 = a;
    exp_q.push_back(a);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    seen = 0;
    for (int m = 1; m <= 60 && seen == 0; m++) begin
      tick();
      if (done2) seen = m;
    end
    check("scan2 done latency", 32'(seen), 32'd48);
    if (seen != 0) pop_frame("scan2 frame", frame2);
    else void'(exp_q.pop_front());
    tick();
  endtask

  initial begin
    int ndone, last, cnt;
    rst2 = 1'b1; rst0 = 1'b1; start2 = 1'b0; start0 = 1'b0;
    a2 = '0; a0 = '0;
    repeat (3) tick();
    rst2 = 1'b0; rst0 = 1'b0;
    tick();
    check("reset sel2", 32'(sel2), 32'd0);
    check("reset busy2", 32'(busy2), 32'd0);
    check("reset done2", 32'(done2), 32'd0);
    check("reset frame2", 32'(frame2), 32'd0);
    check("reset sel0", 32'(sel0), 32'd0);
    check("reset frame0", 32'(frame0), 32'd0);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("reset chg2", 32'(chg2), 32'd0);
    check("reset chg_any2", 32'(chg_any2), 32'd0);
`endif

    // SETTLE=2 single scan: each sel held 3 cycles, done 48 edges after acceptance
    a2 = 16'hA5C3;
    exp_q.push_back(16'hA5C3);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("t1 accept sel", 32'(sel2), 32'd0);
    check("t1 accept busy", 32'(busy2), 32'd1);
    for (int m = 1; m <= 48; m++) begin
      tick();
      check("t1 sel", 32'(sel2), (m < 48) ? 32'(m / 3) : 32'd15);
      check("t1 done", 32'(done2), (m == 48) ? 32'd1 : 32'd0);
      check("t1 busy", 32'(busy2), 32'd1);
      if (m == 20) check("t1 frame hidden mid-scan", 32'(frame2), 32'd0);
      if (done2) pop_frame("t1 frame", frame2);
    end
    tick();
    check("t1 done is one cycle", 32'(done2), 32'd0);
    check("t1 busy after done", 32'(busy2), 32'd0);
    check("t1 sel holds 15", 32'(sel2), 32'd15);
    tick();
    check("t1 sel holds 15 in idle", 32'(sel2), 32'd15);

    // start pulses during a running scan are ignored
    a2 = 16'h1234;
    exp_q.push_back(16'h1234);
    start2 = 1'b1;
    tick();
    ndone = 0;
    for (int m = 1; m <= 80; m++) begin
      start2 = (m == 5) || (m == 10);
      tick();
      if (done2) begin
        ndone++;
        check("t2 done latency", 32'(m), 32'd48);
        pop_frame("t2 frame", frame2);
      end
    end
    start2 = 1'b0;
    check("t2 done count", 32'(ndone), 32'd1);
    check("t2 idle busy", 32'(busy2), 32'd0);

    // reset 20 cycles into a scan aborts it with no done
    a2 = 16'hFFFF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    ndone = 0;
    for (int m = 1; m < 20; m++) begin
      tick();
      if (done2) ndone++;
    end
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("t3 done after rst", 32'(done2), 32'd0);
    check("t3 frame after rst", 32'(frame2), 32'd0);
    check("t3 busy after rst", 32'(busy2), 32'd0);
    check("t3 sel after rst", 32'(sel2), 32'd0);
    for (int m = 0; m < 60; m++) begin
      tick();
      if (done2) ndone++;
    end
    check("t3 no done", 32'(ndone), 32'd0);
    check("t3 still idle", 32'(busy2), 32'd0);

    // SETTLE=0 with start held: scans every 18 cycles, one idle cycle between
    a0 = 16'h0001;
    repeat (3) exp_q.push_back(16'h0001);
    start0 = 1'b1;
    tick();
    check("t4 accept busy", 32'(busy0), 32'd1);
    check("t4 accept sel", 32'(sel0), 32'd0);
    last = -1;
    cnt  = 0;
    for (int m = 1; m <= 70; m++) begin
      tick();
      if (m <= 15) check("t4 sel", 32'(sel0), 32'(m));
      if (last >= 0 && m == last + 1) check("t4 idle gap busy", 32'(busy0), 32'd0);
      if (last >= 0 && m == last + 2 && cnt < 3) check("t4 restart busy", 32'(busy0), 32'd1);
      if (done0) begin
        if (cnt == 0) check("t4 first latency", 32'(m), 32'd16);
        else          check("t4 scan period", 32'(m - last), 32'd18);
        pop_frame("t4 frame", frame0);
        last = m;
        cnt++;
        if (cnt == 3) start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    check("t4 scan count", 32'(cnt), 32'd3);

    // frame sequence; change mask checked when the feature is built in
    scan2(16'h00FF);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("t5 chg 1", 32'(chg2), 32'h00FF);
    check("t5 chg_any 1", 32'(chg_any2), 32'd1);
`endif
    scan2(16'h0F0F);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("t5 chg 2", 32'(chg2), 32'h0FF0);
    check("t5 chg_any 2", 32'(chg_any2), 32'd1);
`endif
    scan2(16'h0F0F);
`ifdef MUX_SCAN_CHANGE_DETECT_EN
    check("t5 chg 3", 32'(chg2), 32'd0);
    check("t5 chg_any 3", 32'(chg_any2), 32'd0);
`endif
    check("t5 frame holds", 32'(frame2), 32'h0F0F);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
